// File: rtl/mem_fifo_ctrl.sv
// In-order FIFO controller backed by an external 1R1W memory with a 2-entry output buffer.
// Optional build macro MEM_FIFO_CTRL_BYPASS_EN routes words straight into the output buffer when memory is empty.
module mem_fifo_ctrl #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  mem_write,
  output logic [DEPTH_LOG2-1:0] mem_write_addr,
  output logic [WIDTH-1:0]      mem_write_data,
  output logic                  mem_read,
  output logic [DEPTH_LOG2-1:0] mem_read_addr,
  input  logic [WIDTH-1:0]      mem_read_data
);

  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [DEPTH_LOG2-1:0] wptr;
  logic [DEPTH_LOG2-1:0] rptr;
  logic [DEPTH_LOG2:0]   mcnt;
  logic [DEPTH_LOG2:0]   mcnt_nxt;
  logic                  full_q;
  logic                  rd_pend;

  logic [WIDTH-1:0]      ob0;
  logic [WIDTH-1:0]      ob1;
  logic [1:0]            ob_cnt;
  logic [1:0]            ob_after_pop;

  logic                  acc;
  logic                  pop;
  logic                  bypass;
  logic                  rd_issue;
  logic                  push;
  logic [WIDTH-1:0]      push_data;

  // Gating with rst_n keeps every output quiet while reset is held.
  assign in_ready  = rst_n & ~full_q;
  assign out_valid = rst_n & (ob_cnt != 2'd0);
  assign out_data  = ob0;

  assign acc          = in_valid & in_ready;
  assign pop          = out_valid & out_ready;
  assign ob_after_pop = ob_cnt - {1'b0, pop};

`ifdef MEM_FIFO_CTRL_BYPASS_EN
  // Safe for ordering: with memory empty and nothing in flight, every older word is already in the OB.
  assign bypass = acc && (mcnt == '0) && !rd_pend && (ob_after_pop < 2'd2);
`else
  assign bypass = 1'b0;
`endif

  // Counting the slot freed by this cycle's pop sustains one word per cycle.
  assign rd_issue = rst_n && (mcnt != '0) &&
                    ((ob_after_pop + {1'b0, rd_pend}) < 2'd2);

  assign mem_write      = acc & ~bypass;
  assign mem_write_addr = wptr;
  assign mem_write_data = in_data;
  assign mem_read       = rd_issue;
  assign mem_read_addr  = rptr;

  assign push      = rd_pend | bypass;
  assign push_data = rd_pend ? mem_read_data : in_data;

  assign mcnt_nxt = mcnt + {{DEPTH_LOG2{1'b0}}, mem_write}
                         - {{DEPTH_LOG2{1'b0}}, rd_issue};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      mcnt    <= '0;
      full_q  <= 1'b0;
      rd_pend <= 1'b0;
      ob0     <= '0;
      ob1     <= '0;
      ob_cnt  <= 2'd0;
    end else begin
      if (mem_write) wptr <= wptr + DEPTH_LOG2'(1);
      if (rd_issue)  rptr <= rptr + DEPTH_LOG2'(1);
      mcnt    <= mcnt_nxt;
      full_q  <= (mcnt_nxt == FULL_CNT);
      rd_pend <= rd_issue;
      if (pop) ob0 <= ob1;
      // A push lands after the pop shift; a later NBA to ob0 overrides the shift.
      if (push) begin
        if (ob_after_pop[0]) ob1 <= push_data;
        else                 ob0 <= push_data;
      end
      ob_cnt <= ob_after_pop + {1'b0, push};
    end
  end

endmodule

// File: tb/tb_mem_fifo_ctrl.sv
// Self-checking bench for mem_fifo_ctrl with a behavioural memory and a queue scoreboard.
module tb_mem_fifo_ctrl;

  localparam int DL = 4;
  localparam int W  = 32;
  localparam int ELEMS = 1 << DL;
`ifdef MEM_FIFO_CTRL_BYPASS_EN
  localparam int LAT = 1;
  localparam bit BYP = 1'b1;
`else
  localparam int LAT = 3;
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          mem_write;
  logic [DL-1:0] mem_write_addr;
  logic [W-1:0]  mem_write_data;
  logic          mem_read;
  logic [DL-1:0] mem_read_addr;
  logic [W-1:0]  mem_read_data;

  logic [W-1:0]  mem [ELEMS];

  int pass_cnt = 0;
  int chk_cnt  = 0;

  logic [W-1:0] q [$];

  logic          s_in_ready, s_out_valid, s_mem_write, s_mem_read;
  logic          s_ifire, s_ofire, s_have_exp, s_coll;
  logic [W-1:0]  s_out_data, s_exp, s_mem_write_data;
  logic [DL-1:0] s_mem_write_addr, s_mem_read_addr;

  always #5 clk = ~clk;

  mem_fifo_ctrl #(.DEPTH_LOG2(DL), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .mem_write(mem_write), .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data),
    .mem_read(mem_read), .mem_read_addr(mem_read_addr), .mem_read_data(mem_read_data)
  );

  always @(posedge clk) begin
    if (mem_write) mem[mem_write_addr] <= mem_write_data;
    if (mem_read)  mem_read_data <= mem[mem_read_addr];
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  // Drive one cycle, sample 1ns later, update the reference queue, advance to next negedge.
  task automatic step(input logic iv, input logic [W-1:0] id, input logic ordy);
    in_valid = iv; in_data = id; out_ready = ordy;
    #1;
    s_in_ready = in_ready;   s_out_valid = out_valid;  s_out_data = out_data;
    s_mem_write = mem_write; s_mem_write_addr = mem_write_addr;
    s_mem_write_data = mem_write_data;
    s_mem_read = mem_read;   s_mem_read_addr = mem_read_addr;
    s_ifire = in_valid & in_ready;
    s_ofire = out_valid & out_ready;
    s_coll  = mem_read & mem_write & (mem_read_addr == mem_write_addr);
    s_have_exp = 1'b0; s_exp = '0;
    if (s_ofire && q.size() > 0) begin
      s_have_exp = 1'b1;
      s_exp = q.pop_front();
    end
    if (s_ifire) q.push_back(id);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(1'b1, 32'h1234_5678, 1'b1);
    chk_cnt++; if (s_in_ready !== 1'b0) $display("FAIL reset_in_ready got %b want 0", s_in_ready); else pass_cnt++;
    chk_cnt++; if (s_out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", s_out_valid); else pass_cnt++;
    chk_cnt++; if (s_mem_write !== 1'b0) $display("FAIL reset_mem_write got %b want 0", s_mem_write); else pass_cnt++;
    chk_cnt++; if (s_mem_read !== 1'b0) $display("FAIL reset_mem_read got %b want 0", s_mem_read); else pass_cnt++;
    step(1'b0, '0, 1'b0);
    rst_n = 1'b1;
    q.delete();
    step(1'b0, '0, 1'b0);
    chk_cnt++; if (s_in_ready !== 1'b1) $display("FAIL release_in_ready got %b want 1", s_in_ready); else pass_cnt++;
    chk_cnt++; if (s_out_valid !== 1'b0) $display("FAIL release_out_valid got %b want 0", s_out_valid); else pass_cnt++;
  endtask

  task automatic test_single();
    step(1'b1, 32'hA5A5_A5A5, 1'b0);
    chk_cnt++; if (s_ifire !== 1'b1) $display("FAIL single_accept got %b want 1", s_ifire); else pass_cnt++;
    chk_cnt++; if (s_mem_write !== !BYP) $display("FAIL single_mem_write got %b want %b", s_mem_write, !BYP); else pass_cnt++;
    if (!BYP) begin
      chk_cnt++;
      if (s_mem_write_addr !== 4'd0 || s_mem_write_data !== 32'hA5A5_A5A5)
        $display("FAIL single_wr_addr_data got %h/%h want 0/a5a5a5a5", s_mem_write_addr, s_mem_write_data);
      else pass_cnt++;
    end
    for (int k = 1; k <= LAT + 2; k++) begin
      step(1'b0, '0, 1'b0);
      chk_cnt++;
      if (s_out_valid !== (k >= LAT)) $display("FAIL single_latency cycle T+%0d got %b want %b", k, s_out_valid, (k >= LAT));
      else pass_cnt++;
      if (k == 1 && !BYP) begin
        chk_cnt++;
        if (s_mem_read !== 1'b1 || s_mem_read_addr !== 4'd0)
          $display("FAIL single_read_issue got %b@%h want 1@0", s_mem_read, s_mem_read_addr);
        else pass_cnt++;
      end
      if (k >= LAT) begin
        chk_cnt++;
        if (s_out_data !== 32'hA5A5_A5A5) $display("FAIL single_out_data got %h want a5a5a5a5", s_out_data);
        else pass_cnt++;
      end
    end
    step(1'b0, '0, 1'b1);
    chk_cnt++;
    if (!s_ofire || !s_have_exp || s_out_data !== s_exp) $display("FAIL single_pop got %h fire %b want %h", s_out_data, s_ofire, s_exp);
    else pass_cnt++;
    step(1'b0, '0, 1'b0);
    chk_cnt++; if (s_out_valid !== 1'b0) $display("FAIL single_empty got %b want 0", s_out_valid); else pass_cnt++;
  endtask

  task automatic test_fill();
    int accepted = 0;
    int drained = 0;
    for (int c = 0; c < 40; c++) begin
      step(1'b1, W'(accepted), 1'b0);
      if (s_ifire) accepted++;
    end
    chk_cnt++; if (accepted != ELEMS + 2) $display("FAIL fill_count got %0d want %0d", accepted, ELEMS + 2); else pass_cnt++;
    chk_cnt++; if (s_in_ready !== 1'b0) $display("FAIL fill_in_ready got %b want 0", s_in_ready); else pass_cnt++;
    for (int c = 0; c < 100 && q.size() > 0; c++) begin
      step(1'b0, '0, 1'b1);
      if (s_ofire) begin
        chk_cnt++;
        if (!s_have_exp || s_out_data !== W'(drained)) $display("FAIL fill_drain_order got %h want %h", s_out_data, W'(drained));
        else pass_cnt++;
        drained++;
      end
    end
    chk_cnt++; if (drained != ELEMS + 2) $display("FAIL fill_drain_count got %0d want %0d", drained, ELEMS + 2); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int accepted = 0;
    int win = 0;
    int cyc = 0;
    while (accepted < 100 && cyc < 300) begin
      step(1'b1, $urandom, 1'b1);
      if (s_ifire) accepted++;
      if (s_ofire) begin
        chk_cnt++;
        if (!s_have_exp || s_out_data !== s_exp) $display("FAIL b2b_data got %h want %h", s_out_data, s_exp);
        else pass_cnt++;
        if (cyc >= 5 && cyc < 100) win++;
      end
      cyc++;
    end
    chk_cnt++; if (cyc != 100) $display("FAIL b2b_accept_cycles got %0d want 100", cyc); else pass_cnt++;
    chk_cnt++; if (win != 95) $display("FAIL b2b_steady_pops got %0d want 95", win); else pass_cnt++;
    for (int c = 0; c < 50 && q.size() > 0; c++) begin
      step(1'b0, '0, 1'b1);
      if (s_ofire) begin
        chk_cnt++;
        if (!s_have_exp || s_out_data !== s_exp) $display("FAIL b2b_drain got %h want %h", s_out_data, s_exp);
        else pass_cnt++;
      end
    end
    chk_cnt++; if (q.size() != 0) $display("FAIL b2b_left got %0d want 0", q.size()); else pass_cnt++;
  endtask

  task automatic test_random();
    logic          pv = 1'b0;
    logic          pf = 1'b0;
    logic [W-1:0]  pd = '0;
    for (int c = 0; c < 10000; c++) begin
      step(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 3) != 0));
      if (pv && !pf) begin
        chk_cnt++;
        if (s_out_valid !== 1'b1 || s_out_data !== pd) $display("FAIL rand_hold got %b/%h want 1/%h", s_out_valid, s_out_data, pd);
        else pass_cnt++;
      end
      if (s_ofire) begin
        chk_cnt++;
        if (!s_have_exp || s_out_data !== s_exp) $display("FAIL rand_data got %h want %h", s_out_data, s_exp);
        else pass_cnt++;
      end
      if (s_mem_read && s_mem_write) begin
        chk_cnt++;
        if (s_coll) $display("FAIL rand_rw_same_addr got %h want != %h", s_mem_read_addr, s_mem_write_addr);
        else pass_cnt++;
      end
      pv = s_out_valid; pf = s_ofire; pd = s_out_data;
    end
    for (int c = 0; c < 100 && q.size() > 0; c++) begin
      step(1'b0, '0, 1'b1);
      if (s_ofire) begin
        chk_cnt++;
        if (!s_have_exp || s_out_data !== s_exp) $display("FAIL rand_drain got %h want %h", s_out_data, s_exp);
        else pass_cnt++;
      end
    end
    chk_cnt++; if (q.size() != 0) $display("FAIL rand_left got %0d want 0", q.size()); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int accepted = 0;
    for (int c = 0; c < 20 && accepted < 5; c++) begin
      step(1'b1, $urandom, 1'b0);
      if (s_ifire) accepted++;
    end
    repeat (4) step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b1);
    chk_cnt++;
    if (!s_ofire || !s_have_exp || s_out_data !== s_exp) $display("FAIL mid_pop got %h want %h", s_out_data, s_exp);
    else pass_cnt++;
    chk_cnt++; if (s_mem_read !== 1'b1) $display("FAIL mid_read_in_flight got %b want 1", s_mem_read); else pass_cnt++;
    rst_n = 1'b0;
    step(1'b0, '0, 1'b0);
    rst_n = 1'b1;
    q.delete();
    step(1'b0, '0, 1'b1);
    chk_cnt++; if (s_out_valid !== 1'b0) $display("FAIL mid_out_valid got %b want 0", s_out_valid); else pass_cnt++;
    chk_cnt++; if (s_in_ready !== 1'b1) $display("FAIL mid_in_ready got %b want 1", s_in_ready); else pass_cnt++;
    for (int k = 0; k < 4; k++) begin
      step(1'b0, '0, 1'b1);
      chk_cnt++; if (s_out_valid !== 1'b0) $display("FAIL mid_stale got %b want 0", s_out_valid); else pass_cnt++;
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
